i2c_rpt_arb: RTL and testbench
==============================

# i2c_rpt_arb

Arbiter and sequencer for the shared downstream repeater path behind the two I2C slave channels (a, b). It watches each channel's START/STOP/SCL-fall detector pulses and grants the single downstream path to one channel per transaction. It stretches the losing channel through its `rpt_x_hold` input and routes downstream SDA back through `rpt_x_sda`. It sits beside the two slave instances in the top level and drives their `rpt_*` inputs directly.

## Interface
Parameters:
- GUARD, 4: idle cycles in RELEASE between ownership changes (1..15).
- TO_W, 8: width of the ownership timeout counter.

Ports:
- ck_ref  in  1  clock; one clock domain only.
- rst_ref  in  1  reset, synchronous, active-high.
- test_mode  in  1  forces the bypass state (see Operation).
- r_arb_timeout  in  TO_W  cycles without an owner SCL fall before forced release; 0 disables the timeout.
- i2c_a_spc_start / i2c_b_spc_start  in  1  single-cycle START detected on the channel.
- i2c_a_spc_stop / i2c_b_spc_stop  in  1  single-cycle STOP detected.
- i2c_a_spc_scl_fall / i2c_b_spc_scl_fall  in  1  single-cycle SCL falling edge.
- i2c_a_spc_sda_state / i2c_b_spc_sda_state  in  1  filtered SDA level of the channel.
- dn_sda_in  in  1  sampled SDA of the shared downstream bus.
- rpt_a_hold / rpt_b_hold  out  1  stretch request to the slave channel.
- rpt_a_sda / rpt_b_sda  out  1  downstream SDA returned to the channel.
- dn_sda_out  out  1  SDA driven to the downstream bus (1 = release).
- grant_a / grant_b  out  1  one-hot ownership status; both low when there is no owner.
- arb_to_pulse  out  1  single-cycle pulse on a timeout release.

## Operation
- State machine has five states: IDLE, OWN_A, OWN_B, RELEASE, BYPASS.
- Pending flags pend_a and pend_b:
  - A flag is set on its channel's spc_start while that channel is not the owner.
  - A flag is cleared on its channel's spc_stop, or when the channel is granted.
- IDLE:
  - If only one flag is pending, grant that channel.
  - If both are pending, grant the channel opposite last_grant (round-robin).
  - last_grant resets to b, so a wins the first tie.
- OWN_x:
  - grant_x = 1 and rpt_x_hold = 0.
  - dn_sda_out = i2c_x_spc_sda_state and rpt_x_sda = dn_sda_in.
  - The non-owner sees rpt_y_hold = pend_y and rpt_y_sda = 1.
  - The timeout counter clears on the owner's scl_fall and otherwise increments, saturating.
  - Owner spc_stop moves to RELEASE.
  - Counter reaching r_arb_timeout (nonzero) moves to RELEASE and asserts arb_to_pulse.
- RELEASE:
  - No grants, dn_sda_out = 1, holds equal their pending flags.
  - Stays for GUARD cycles, then goes to IDLE.
- Simultaneous events:
  - A start and a stop on the same channel in the same cycle: stop wins and the flag ends cleared.
  - An owner stop and a non-owner start in the same cycle: the flag is set and the grant is taken after the guard.
  - The owner's own spc_start (repeated START) keeps ownership and clears the timeout counter.
- test_mode = 1 from any state goes to BYPASS next cycle:
  - All holds 0, no grants, dn_sda_out = 1, rpt_x_sda = 1.
  - Pending flags and counters are cleared.
  - Deasserting test_mode returns to IDLE.
- Reset values: state IDLE, all holds 0, rpt_a_sda = rpt_b_sda = 1, dn_sda_out = 1, grants 0, arb_to_pulse 0, flags 0, counters 0.

## Timing
- Every output is registered.
- A spc_start at cycle N in IDLE produces the grant, the hold change and the SDA routing at N+1.
- Path latency: dn_sda_in to rpt_x_sda is 1 cycle; i2c_x_spc_sda_state to dn_sda_out is 1 cycle.
- Owner stop at N: RELEASE is visible at N+1, IDLE at N+1+GUARD, and the next grant at N+2+GUARD.
- Timeout: with r_arb_timeout = T and the last owner scl_fall at N, arb_to_pulse is high at N+T+1 together with RELEASE.
- Changing r_arb_timeout mid-ownership takes effect at the next compare.
- Reset asserted mid-ownership returns every output to its reset value one edge later; there is no partial release.

## Structure
- The shared package i2c_pkg holds:
  - the state enum arb_state_t (IDLE, OWN_A, OWN_B, RELEASE, BYPASS);
  - the constants for reset SDA level (1) and default GUARD.
- One sub-module, i2c_rpt_arb_chan, is instantiated twice. It holds the per-channel pending flag and the hold/SDA output muxing.
- The top module holds the FSM, the timeout counter, the guard counter and last_grant.

## Test plan
- Single request: a_start at cycle 10 -> grant_a = 1 and rpt_b_hold = 0 at 11; a_stop at 30 -> RELEASE at 31, IDLE at 35 (GUARD = 4).
- Tie: a_start and b_start at the same cycle out of reset -> grant_a; after a releases, grant_b and rpt_b_hold = 0 at stop + 6.
- Contention: b_start while A owns -> rpt_b_hold = 1 the next cycle and stays 1 until grant_b.
- Timeout: r_arb_timeout = 20 with no SCL falls after the grant -> arb_to_pulse at grant + 21, grants drop, and the pending B is granted after the guard.
- Routing: in OWN_A, toggle dn_sda_in 0/1 -> rpt_a_sda follows 1 cycle later and rpt_b_sda stays 1; dn_sda_out tracks a's SDA state.
- Mode changes: test_mode pulsed mid-OWN_B -> next cycle all holds 0 and grants 0; rst_ref asserted mid-OWN_A -> all outputs at reset values one edge later.

Source files
------------

// File: rtl/i2c_rpt_arb_pkg.sv
// Shared types and constants for the two-channel I2C repeater arbiter.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OWN_A   = 3'd1,
    OWN_B   = 3'd2,
    RELEASE = 3'd3,
    BYPASS  = 3'd4
  } arb_state_t;

  localparam logic SDA_RST   = 1'b1;
  localparam int   GUARD_DEF = 4;

endpackage

// File: rtl/i2c_rpt_arb_chan.sv
// Per-channel pending flag plus registered hold / returned-SDA outputs.
module i2c_rpt_arb_chan
  import i2c_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic own_q_i,
  input  logic own_d_i,
  input  logic clr_i,
  input  logic dn_sda_i,
  output logic req_o,
  output logic hold_o,
  output logic sda_o
);

  logic pend_q, pend_d;
  logic hold_q, hold_d;
  logic sda_q, sda_d;

  // Request as seen this cycle: a stop always wins over a same-cycle start.
  assign req_o = ~stop_i & (pend_q | (start_i & ~own_q_i));

  always_comb begin
    pend_d = (clr_i | own_d_i) ? 1'b0 : req_o;
    hold_d = pend_d;
    sda_d  = own_d_i ? dn_sda_i : SDA_RST;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pend_q <= 1'b0;
      hold_q <= 1'b0;
      sda_q  <= SDA_RST;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      sda_q  <= sda_d;
    end
  end

  assign hold_o = hold_q;
  assign sda_o  = sda_q;

endmodule

// File: rtl/i2c_rpt_arb.sv
// Grants the shared downstream repeater path to channel a or b per transaction,
// with round-robin tie-break, a post-release guard gap and an ownership timeout.
module i2c_rpt_arb
  import i2c_pkg::*;
#(
  parameter int GUARD = GUARD_DEF,
  parameter int TO_W  = 8
) (
  input  logic            ck_ref,
  input  logic            rst_ref,
  input  logic            test_mode,
  input  logic [TO_W-1:0] r_arb_timeout,
  input  logic            i2c_a_spc_start,
  input  logic            i2c_b_spc_start,
  input  logic            i2c_a_spc_stop,
  input  logic            i2c_b_spc_stop,
  input  logic            i2c_a_spc_scl_fall,
  input  logic            i2c_b_spc_scl_fall,
  input  logic            i2c_a_spc_sda_state,
  input  logic            i2c_b_spc_sda_state,
  input  logic            dn_sda_in,
  output logic            rpt_a_hold,
  output logic            rpt_b_hold,
  output logic            rpt_a_sda,
  output logic            rpt_b_sda,
  output logic            dn_sda_out,
  output logic            grant_a,
  output logic            grant_b,
  output logic            arb_to_pulse
);

  arb_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [3:0]      guard_q, guard_d;
  logic            last_b_q, last_b_d;
  logic            first_q;
  logic            to_d;
  logic            grant_a_q, grant_b_q, dout_q, to_q;
  logic            req_a, req_b;
  logic            own_fall, own_start, own_stop;
  logic            own_a_d, own_b_d, clr_d;

  assign own_a_d = (state_d == OWN_A);
  assign own_b_d = (state_d == OWN_B);
  assign clr_d   = (state_d == BYPASS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    last_b_d  = last_b_q;
    to_d      = 1'b0;
    own_fall  = (state_q == OWN_A) ? i2c_a_spc_scl_fall : i2c_b_spc_scl_fall;
    own_start = (state_q == OWN_A) ? i2c_a_spc_start    : i2c_b_spc_start;
    own_stop  = (state_q == OWN_A) ? i2c_a_spc_stop     : i2c_b_spc_stop;
    if (test_mode) begin
      state_d = BYPASS;
      cnt_d   = '0;
      guard_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          guard_d = '0;
          if (req_a && (!req_b || last_b_q)) begin
            state_d  = OWN_A;
            last_b_d = 1'b0;
          end else if (req_b) begin
            state_d  = OWN_B;
            last_b_d = 1'b1;
          end
        end
        OWN_A, OWN_B: begin
          // The first owned cycle counts as a fresh SCL edge for the timeout.
          if (own_fall || own_start || first_q) cnt_d = '0;
          else if (cnt_q != '1)                 cnt_d = cnt_q + TO_W'(1);
          if (own_stop) begin
            state_d = RELEASE;
            guard_d = '0;
          end else if ((r_arb_timeout != '0) && (cnt_d >= r_arb_timeout)) begin
            state_d = RELEASE;
            guard_d = '0;
            to_d    = 1'b1;
          end
        end
        RELEASE: begin
          cnt_d = '0;
          if (guard_q == 4'(GUARD - 1)) state_d = IDLE;
          else                          guard_d = guard_q + 4'd1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          guard_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ck_ref) begin
    if (rst_ref) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      guard_q   <= '0;
      last_b_q  <= 1'b1;
      first_q   <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      dout_q    <= SDA_RST;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      guard_q   <= guard_d;
      last_b_q  <= last_b_d;
      first_q   <= (own_a_d && state_q != OWN_A) || (own_b_d && state_q != OWN_B);
      grant_a_q <= own_a_d;
      grant_b_q <= own_b_d;
      dout_q    <= own_a_d ? i2c_a_spc_sda_state :
                   own_b_d ? i2c_b_spc_sda_state : SDA_RST;
      to_q      <= to_d;
    end
  end

  i2c_rpt_arb_chan u_chan_a (
    .clk_i    (ck_ref),
    .srst_i   (rst_ref),
    .start_i  (i2c_a_spc_start),
    .stop_i   (i2c_a_spc_stop),
    .own_q_i  (state_q == OWN_A),
    .own_d_i  (own_a_d),
    .clr_i    (clr_d),
    .dn_sda_i (dn_sda_in),
    .req_o    (req_a),
    .hold_o   (rpt_a_hold),
    .sda_o    (rpt_a_sda)
  );

  i2c_rpt_arb_chan u_chan_b (
    .clk_i    (ck_ref),
    .srst_i   (rst_ref),
    .start_i  (i2c_b_spc_start),
    .stop_i   (i2c_b_spc_stop),
    .own_q_i  (state_q == OWN_B),
    .own_d_i  (own_b_d),
    .clr_i    (clr_d),
    .dn_sda_i (dn_sda_in),
    .req_o    (req_b),
    .hold_o   (rpt_b_hold),
    .sda_o    (rpt_b_sda)
  );

  assign grant_a      = grant_a_q;
  assign grant_b      = grant_b_q;
  assign dn_sda_out   = dout_q;
  assign arb_to_pulse = to_q;

endmodule

// File: tb/tb_i2c_rpt_arb.sv
// Directed vector table plus hand-written multi-cycle sequences for i2c_rpt_arb.
module tb_i2c_rpt_arb;

  logic       ck_ref = 1'b0;
  logic       rst_ref = 1'b1;
  logic       test_mode = 1'b0;
  logic [7:0] r_arb_timeout = 8'd0;
  logic       i2c_a_spc_start = 1'b0, i2c_b_spc_start = 1'b0;
  logic       i2c_a_spc_stop = 1'b0, i2c_b_spc_stop = 1'b0;
  logic       i2c_a_spc_scl_fall = 1'b0, i2c_b_spc_scl_fall = 1'b0;
  logic       i2c_a_spc_sda_state = 1'b1, i2c_b_spc_sda_state = 1'b1;
  logic       dn_sda_in = 1'b1;
  logic       rpt_a_hold, rpt_b_hold, rpt_a_sda, rpt_b_sda;
  logic       dn_sda_out, grant_a, grant_b, arb_to_pulse;

  int n_chk = 0;
  int n_pass = 0;

  always #5 ck_ref = ~ck_ref;

  i2c_rpt_arb #(.GUARD(4), .TO_W(8)) dut (
    .ck_ref              (ck_ref),
    .rst_ref             (rst_ref),
    .test_mode           (test_mode),
    .r_arb_timeout       (r_arb_timeout),
    .i2c_a_spc_start     (i2c_a_spc_start),
    .i2c_b_spc_start     (i2c_b_spc_start),
    .i2c_a_spc_stop      (i2c_a_spc_stop),
    .i2c_b_spc_stop      (i2c_b_spc_stop),
    .i2c_a_spc_scl_fall  (i2c_a_spc_scl_fall),
    .i2c_b_spc_scl_fall  (i2c_b_spc_scl_fall),
    .i2c_a_spc_sda_state (i2c_a_spc_sda_state),
    .i2c_b_spc_sda_state (i2c_b_spc_sda_state),
    .dn_sda_in           (dn_sda_in),
    .rpt_a_hold          (rpt_a_hold),
    .rpt_b_hold          (rpt_b_hold),
    .rpt_a_sda           (rpt_a_sda),
    .rpt_b_sda           (rpt_b_sda),
    .dn_sda_out          (dn_sda_out),
    .grant_a             (grant_a),
    .grant_b             (grant_b),
    .arb_to_pulse        (arb_to_pulse)
  );

  // Observed vector: {grant_a, grant_b, hold_a, hold_b, sda_a, sda_b, dn_sda_out, to_pulse}
  function automatic logic [7:0] obs();
    return {grant_a, grant_b, rpt_a_hold, rpt_b_hold, rpt_a_sda, rpt_b_sda, dn_sda_out, arb_to_pulse};
  endfunction

  localparam logic [7:0] RST_OBS = 8'b00_00_11_1_0;

  // Channel nibble: {start, stop, scl_fall, sda_state}
  typedef struct {
    string      name;
    logic       tm;
    logic [3:0] a;
    logic [3:0] b;
    logic       dn;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [21];

  task automatic step();
    @(posedge ck_ref);
    #1;
  endtask

  task automatic idle_in();
    test_mode = 1'b0;
    {i2c_a_spc_start, i2c_a_spc_stop, i2c_a_spc_scl_fall, i2c_a_spc_sda_state} = 4'b0001;
    {i2c_b_spc_start, i2c_b_spc_stop, i2c_b_spc_scl_fall, i2c_b_spc_sda_state} = 4'b0001;
    dn_sda_in = 1'b1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %-14s got %b", name, act);
    end else begin
      $display("FAIL %-14s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    idle_in();
    rst_ref = 1'b1;
    step();
    step();
    rst_ref = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"idle",       1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[1]  = '{"a_start",    1'b0, 4'b1001, 4'b0001, 1'b1, 8'b10_00_11_1_0};
    tbl[2]  = '{"route0",     1'b0, 4'b0000, 4'b0001, 1'b0, 8'b10_00_01_0_0};
    tbl[3]  = '{"route1",     1'b0, 4'b0001, 4'b0001, 1'b0, 8'b10_00_01_1_0};
    tbl[4]  = '{"route2",     1'b0, 4'b0000, 4'b0001, 1'b1, 8'b10_00_11_0_0};
    tbl[5]  = '{"b_contend",  1'b0, 4'b0001, 4'b1001, 1'b1, 8'b10_01_11_1_0};
    tbl[6]  = '{"b_held",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b10_01_11_1_0};
    tbl[7]  = '{"a_stop_rel", 1'b0, 4'b0101, 4'b0001, 1'b1, 8'b00_01_11_1_0};
    tbl[8]  = '{"guard1",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_01_11_1_0};
    tbl[9]  = '{"guard2",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_01_11_1_0};
    tbl[10] = '{"guard3",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_01_11_1_0};
    tbl[11] = '{"idle_gap",   1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_01_11_1_0};
    tbl[12] = '{"grant_b",    1'b0, 4'b0001, 4'b0001, 1'b1, 8'b01_00_11_1_0};
    tbl[13] = '{"b_route",    1'b0, 4'b0001, 4'b0000, 1'b0, 8'b01_00_10_0_0};
    tbl[14] = '{"b_start_stp",1'b0, 4'b0001, 4'b1100, 1'b1, 8'b00_00_11_1_0};
    tbl[15] = '{"rel_b1",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[16] = '{"rel_b2",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[17] = '{"rel_b3",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[18] = '{"idle_b",     1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[19] = '{"a_start_stp",1'b0, 4'b1101, 4'b0001, 1'b1, 8'b00_00_11_1_0};
    tbl[20] = '{"a_no_pend",  1'b0, 4'b0001, 4'b0001, 1'b1, 8'b00_00_11_1_0};

    do_reset();
    chk("reset", obs(), RST_OBS);

    for (int i = 0; i < 21; i++) begin
      test_mode = tbl[i].tm;
      {i2c_a_spc_start, i2c_a_spc_stop, i2c_a_spc_scl_fall, i2c_a_spc_sda_state} = tbl[i].a;
      {i2c_b_spc_start, i2c_b_spc_stop, i2c_b_spc_scl_fall, i2c_b_spc_sda_state} = tbl[i].b;
      dn_sda_in = tbl[i].dn;
      step();
      chk(tbl[i].name, obs(), tbl[i].exp);
    end

    // Tie out of reset: a wins, b granted at stop + 6.
    do_reset();
    i2c_a_spc_start = 1'b1; i2c_b_spc_start = 1'b1;
    step();
    idle_in();
    chk("tie_grant_a", obs(), 8'b10_01_11_1_0);
    i2c_a_spc_stop = 1'b1;
    step();
    idle_in();
    for (int k = 0; k < 4; k++) step();
    chk("tie_stop+5", {6'd0, grant_b, rpt_b_hold}, 8'b0000_0001);
    step();
    chk("tie_stop+6", {6'd0, grant_b, rpt_b_hold}, 8'b0000_0010);

    // Timeout with T = 20 and no SCL falls after the grant.
    do_reset();
    r_arb_timeout = 8'd20;
    i2c_a_spc_start = 1'b1;
    step();
    idle_in();
    chk("to_grant", {7'd0, grant_a}, 8'd1);
    i2c_b_spc_start = 1'b1;
    step();
    idle_in();
    chk("to_b_pend", {7'd0, rpt_b_hold}, 8'd1);
    for (int k = 0; k < 19; k++) step();
    chk("to_g+20", {6'd0, grant_a, arb_to_pulse}, 8'b10);
    step();
    chk("to_g+21", {5'd0, grant_a, grant_b, arb_to_pulse}, 8'b001);
    step();
    chk("to_g+22", {7'd0, arb_to_pulse}, 8'd0);
    for (int k = 0; k < 3; k++) step();
    chk("to_g+25", {7'd0, grant_b}, 8'd0);
    step();
    chk("to_g+26", {6'd0, grant_b, rpt_b_hold}, 8'b10);
    // Owner SCL fall at N with timeout lowered to 3: pulse at N+4.
    i2c_b_spc_scl_fall = 1'b1;
    r_arb_timeout = 8'd3;
    step();
    idle_in();
    step();
    step();
    chk("scl_n+3", {6'd0, grant_b, arb_to_pulse}, 8'b10);
    step();
    chk("scl_n+4", {6'd0, grant_b, arb_to_pulse}, 8'b01);
    r_arb_timeout = 8'd0;

    // test_mode pulsed while B owns with A pending.
    do_reset();
    i2c_b_spc_start = 1'b1;
    step();
    idle_in();
    chk("tm_grant_b", {7'd0, grant_b}, 8'd1);
    i2c_a_spc_start = 1'b1;
    step();
    idle_in();
    chk("tm_a_pend", {7'd0, rpt_a_hold}, 8'd1);
    test_mode = 1'b1;
    step();
    chk("tm_bypass", obs(), RST_OBS);
    test_mode = 1'b0;
    step();
    chk("tm_idle", obs(), RST_OBS);
    step();
    chk("tm_flags_clr", obs(), RST_OBS);

    // Reset asserted mid-ownership of A.
    do_reset();
    i2c_a_spc_start = 1'b1;
    step();
    idle_in();
    i2c_b_spc_start = 1'b1;
    dn_sda_in = 1'b0;
    step();
    idle_in();
    dn_sda_in = 1'b0;
    chk("rst_pre", obs(), 8'b10_01_01_1_0);
    rst_ref = 1'b1;
    step();
    chk("rst_mid_own", obs(), RST_OBS);
    rst_ref = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
